// File: rtl/tdc_data_rx.sv
// Serial receiver for the TDC hit stream: start/data/stop framing, a show-ahead output FIFO
// with valid/ready handshake, and saturating word / framing-error / overflow counters.
module tdc_data_rx #(
    parameter int WORD_W     = 24,
    parameter int BX_W       = 16,
    parameter int TOT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RESETB,
    input  logic              DATA_IN,
    input  logic              ENABLE,
    input  logic              CNT_CLEAR,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic [BX_W-1:0]   RX_BX,
    output logic [TOT_W-1:0]  RX_TOT,
    output logic [CNT_W-1:0]  RX_WORD_CNT,
    output logic [7:0]        RX_ERR_CNT,
    output logic [7:0]        RX_OVF_CNT
);

    localparam int BIT_CNT_W = $clog2(WORD_W);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_ZERO  = BIT_CNT_W'(0);
    localparam logic [LVL_W-1:0]     DEPTH_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]     LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]     LVL_ZERO  = LVL_W'(0);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ZERO  = PTR_W'(0);
    localparam logic [CNT_W-1:0]     WCNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     WCNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     WCNT_ZERO = CNT_W'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic                 din_q;
    logic [1:0]           state_q,   state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]    shreg_q,   shreg_d;
    logic                 push_s;
    logic                 frame_err_s;

    logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,  rd_ptr_d;
    logic [LVL_W-1:0]     lvl_q,     lvl_d;
    logic [LVL_W-1:0]     rem_s;
    logic                 valid_q,   valid_d;
    logic [WORD_W-1:0]    head_q,    head_d;
    logic                 pop_s;
    logic                 accept_s;
    logic                 ovf_s;

    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [7:0]           err_cnt_q,  err_cnt_d;
    logic [7:0]           ovf_cnt_q,  ovf_cnt_d;

    // Line sampling: the FSM only ever looks at the registered copy of DATA_IN.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            din_q <= 1'b0;
        end else begin
            din_q <= DATA_IN;
        end
    end

    // Frame FSM next-state; dropping ENABLE abandons any partial frame without side effects.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
        if (!ENABLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (din_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = BIT_ZERO;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {shreg_q[WORD_W-2:0], din_q};
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (din_q) begin
                        frame_err_s = 1'b1;
                    end else begin
                        push_s      = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Frame FSM state registers.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= BIT_ZERO;
            shreg_q   <= {WORD_W{1'b0}};
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // A push into a full FIFO still fits when the head leaves in the same cycle.
    always_comb begin
        pop_s    = valid_q & RX_READY;
        accept_s = push_s & ((lvl_q != DEPTH_LVL) | pop_s);
        ovf_s    = push_s & ~accept_s;

        wr_ptr_d = accept_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s    ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        rem_s    = pop_s    ? (lvl_q - LVL_ONE)    : lvl_q;

        case ({accept_s, pop_s})
            2'b10:   lvl_d = lvl_q + LVL_ONE;
            2'b01:   lvl_d = lvl_q - LVL_ONE;
            default: lvl_d = lvl_q;
        endcase

        valid_d = (lvl_d != LVL_ZERO);

        // Head register: next oldest word, or the incoming word if nothing older remains.
        if (lvl_d == LVL_ZERO) begin
            head_d = head_q;
        end else if (rem_s == LVL_ZERO) begin
            head_d = shreg_q;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage, pointers, fill level and the registered head/valid outputs.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {WORD_W{1'b0}};
            end
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            lvl_q    <= LVL_ZERO;
            valid_q  <= 1'b0;
            head_q   <= {WORD_W{1'b0}};
        end else begin
            if (accept_s) begin
                mem_q[wr_ptr_q] <= shreg_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Saturating counters; a clear wins over an increment in the same cycle.
    always_comb begin
        if (CNT_CLEAR) begin
            word_cnt_d = WCNT_ZERO;
            err_cnt_d  = 8'h00;
            ovf_cnt_d  = 8'h00;
        end else begin
            if (accept_s && (word_cnt_q != WCNT_MAX)) begin
                word_cnt_d = word_cnt_q + WCNT_ONE;
            end else begin
                word_cnt_d = word_cnt_q;
            end
            if (frame_err_s && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'h01;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (ovf_s && (ovf_cnt_q != 8'hFF)) begin
                ovf_cnt_d = ovf_cnt_q + 8'h01;
            end else begin
                ovf_cnt_d = ovf_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            word_cnt_q <= WCNT_ZERO;
            err_cnt_q  <= 8'h00;
            ovf_cnt_q  <= 8'h00;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign RX_VALID    = valid_q;
    assign RX_BX       = head_q[WORD_W-1:TOT_W];
    assign RX_TOT      = head_q[TOT_W-1:0];
    assign RX_WORD_CNT = word_cnt_q;
    assign RX_ERR_CNT  = err_cnt_q;
    assign RX_OVF_CNT  = ovf_cnt_q;

endmodule
